// File: rtl/wgt_glb_seq_if.sv
// Bus bundle between the weight-GLB sequencer and its environment.
// Covers the job controls, the input and output row streams, and the GLB port set.
`ifndef WGT_GLB_NUM_ROWS
`define WGT_GLB_NUM_ROWS 64
`endif
`ifndef WGT_GLB_NUM_BITS
`define WGT_GLB_NUM_BITS 8
`endif

interface wgt_glb_seq_if #(
   parameter int unsigned WGT_GLB_NUM_ROWS   = `WGT_GLB_NUM_ROWS,
   parameter int unsigned WGT_GLB_ADDR_WIDTH = $clog2(WGT_GLB_NUM_ROWS),
   parameter int unsigned WGT_GLB_NUM_BITS   = `WGT_GLB_NUM_BITS,
   parameter int unsigned PASS_WIDTH         = 4
);
   logic                          w_start;
   logic [PASS_WIDTH-1:0]         w_num_passes;
   logic                          w_in_valid;
   logic                          w_in_ready;
   logic [WGT_GLB_NUM_BITS-1:0]   w_in_data;
   logic                          w_out_valid;
   logic                          w_out_ready;
   logic [WGT_GLB_NUM_BITS-1:0]   w_out_data;
   logic                          w_out_last;
   logic                          w_busy;
   logic                          w_done;
   logic                          w_glb_ready;
   logic                          w_glb_rw;
   logic                          w_glb_add;
   logic [WGT_GLB_ADDR_WIDTH-1:0] w_glb_address;
   logic [WGT_GLB_NUM_BITS-1:0]   w_glb_data_in;
   logic [WGT_GLB_NUM_BITS-1:0]   w_glb_data_out;

   // Sequencer side
   modport master (
      input  w_start, w_num_passes, w_in_valid, w_in_data, w_out_ready, w_glb_data_out,
      output w_in_ready, w_out_valid, w_out_data, w_out_last, w_busy, w_done,
             w_glb_ready, w_glb_rw, w_glb_add, w_glb_address, w_glb_data_in
   );

   // Environment side: job source, row sink and the GLB itself
   modport slave (
      output w_start, w_num_passes, w_in_valid, w_in_data, w_out_ready, w_glb_data_out,
      input  w_in_ready, w_out_valid, w_out_data, w_out_last, w_busy, w_done,
             w_glb_ready, w_glb_rw, w_glb_add, w_glb_address, w_glb_data_in
   );
endinterface

// File: rtl/wgt_glb_seq.sv
// Weight-GLB sequencer: accumulates streamed rows over N passes, then drains all rows.
// Define WGT_GLB_SEQ_CLEAR_EN to zero the GLB in a one-cycle CLEAR state before DONE.
`ifndef WGT_GLB_NUM_ROWS
`define WGT_GLB_NUM_ROWS 64
`endif
`ifndef WGT_GLB_NUM_BITS
`define WGT_GLB_NUM_BITS 8
`endif

module wgt_glb_seq #(
   parameter int unsigned WGT_GLB_NUM_ROWS   = `WGT_GLB_NUM_ROWS,
   parameter int unsigned WGT_GLB_ADDR_WIDTH = $clog2(WGT_GLB_NUM_ROWS),
   parameter int unsigned WGT_GLB_NUM_BITS   = `WGT_GLB_NUM_BITS,
   parameter int unsigned PASS_WIDTH         = 4
) (
   input  logic          w_clock,
   input  logic          w_reset_n,
   wgt_glb_seq_if.master bus
);
   localparam int unsigned AW = WGT_GLB_ADDR_WIDTH;
   localparam int unsigned PW = PASS_WIDTH;
   localparam logic [AW-1:0] LAST_ROW = AW'(WGT_GLB_NUM_ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ACC, S_RD_ADDR, S_RD_DATA, S_CLEAR, S_DONE
   } state_t;

   state_t        state;
   logic [AW-1:0] row;
   logic [PW-1:0] pass;
   logic [PW-1:0] passes;
   logic          in_ready_q;
   logic          out_valid_q;
   logic          out_last_q;
   logic          busy_q;
   logic          done_q;
   logic          in_fire;

   assign in_fire         = in_ready_q & bus.w_in_valid;
   assign bus.w_in_ready  = in_ready_q;
   assign bus.w_out_valid = out_valid_q;
   assign bus.w_out_last  = out_last_q;
   assign bus.w_out_data  = bus.w_glb_data_out;
   assign bus.w_busy      = busy_q;
   assign bus.w_done      = done_q;

   // GLB drives are combinational so an accepted row is written on its handshake edge
   always_comb begin
      bus.w_glb_ready   = w_reset_n;
      bus.w_glb_rw      = 1'b0;
      bus.w_glb_add     = 1'b0;
      bus.w_glb_address = '0;
      bus.w_glb_data_in = '0;
`ifdef WGT_GLB_SEQ_CLEAR_EN
      if (state == S_CLEAR) bus.w_glb_ready = 1'b0;
`endif
      if (w_reset_n) begin
         if (state == S_ACC || state == S_RD_ADDR || state == S_RD_DATA)
            bus.w_glb_address = row;
         if (in_fire) begin
            bus.w_glb_rw      = 1'b1;
            bus.w_glb_add     = (pass != '0);
            bus.w_glb_data_in = bus.w_in_data;
         end
      end
   end

   always_ff @(posedge w_clock) begin
      if (!w_reset_n) begin
         state       <= S_IDLE;
         row         <= '0;
         pass        <= '0;
         passes      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.w_start) begin
                  passes     <= (bus.w_num_passes == '0) ? PW'(1) : bus.w_num_passes;
                  row        <= '0;
                  pass       <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state      <= S_ACC;
               end
            end
            S_ACC: begin
               if (in_fire) begin
                  if (row == LAST_ROW) begin
                     row <= '0;
                     if (pass == passes - PW'(1)) begin
                        in_ready_q <= 1'b0;
                        state      <= S_RD_ADDR;
                     end else begin
                        pass <= pass + PW'(1);
                     end
                  end else begin
                     row <= row + AW'(1);
                  end
               end
            end
            S_RD_ADDR: begin
               out_valid_q <= 1'b1;
               out_last_q  <= (row == LAST_ROW);
               state       <= S_RD_DATA;
            end
            // Address and read stay asserted, so the GLB output holds under backpressure
            S_RD_DATA: begin
               if (bus.w_out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (row == LAST_ROW) begin
`ifdef WGT_GLB_SEQ_CLEAR_EN
                     state <= S_CLEAR;
`else
                     state  <= S_DONE;
                     done_q <= 1'b1;
`endif
                  end else begin
                     row   <= row + AW'(1);
                     state <= S_RD_ADDR;
                  end
               end
            end
            S_CLEAR: begin
               state  <= S_DONE;
               done_q <= 1'b1;
            end
            S_DONE: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wgt_glb_seq.sv
// Directed bench for wgt_glb_seq with a behavioural weight GLB attached.
`timescale 1ns/1ps
module tb_wgt_glb_seq;
   localparam int unsigned NR = 64;
   localparam int unsigned AW = 6;
   localparam int unsigned NB = 8;
   localparam int unsigned PW = 4;
`ifdef WGT_GLB_SEQ_CLEAR_EN
   localparam int EXP_CLR = 1;
`else
   localparam int EXP_CLR = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wgt_glb_seq_if #(.WGT_GLB_NUM_ROWS(NR), .WGT_GLB_ADDR_WIDTH(AW),
                    .WGT_GLB_NUM_BITS(NB), .PASS_WIDTH(PW)) bus ();
   wgt_glb_seq #(.WGT_GLB_NUM_ROWS(NR), .WGT_GLB_ADDR_WIDTH(AW),
                 .WGT_GLB_NUM_BITS(NB), .PASS_WIDTH(PW))
      dut (.w_clock(clk), .w_reset_n(rst_n), .bus(bus));

   // GLB model: clear on !ready, write/add on rw, registered read otherwise
   logic [NB-1:0] mem [NR];
   logic [NB-1:0] glb_q;
   always @(posedge clk) begin
      if (!bus.w_glb_ready) begin
         for (int i = 0; i < NR; i++) mem[i] <= '0;
      end else if (bus.w_glb_rw) begin
         mem[bus.w_glb_address] <= bus.w_glb_add ? mem[bus.w_glb_address] + bus.w_glb_data_in
                                                 : bus.w_glb_data_in;
      end else begin
         glb_q <= mem[bus.w_glb_address];
      end
   end
   // Floating output while writing is modelled as corrupted data
   assign bus.w_glb_data_out = bus.w_glb_rw ? ~glb_q : glb_q;

   int checks = 0;
   int passed = 0;
   int done_cnt = 0;
   int bus_viol = 0;
   always @(negedge clk) begin
      if (bus.w_done) done_cnt++;
      if (bus.w_out_valid && bus.w_glb_rw) bus_viol++;
   end

   logic [NB-1:0] dr_vals [NR];
   int dr_n, dr_last_cnt, dr_last_row, dr_clr;
   bit dr_stall_ok, dr_clr_before_done, dr_ok;

   task automatic start_job(input int np);
      bus.w_start = 1'b1;
      bus.w_num_passes = PW'(np);
      @(negedge clk);
      bus.w_start = 1'b0;
   endtask

   task automatic feed(input int np, input logic [NB-1:0] base, input logic [NB-1:0] step,
                       input bit gaps, output bit ok);
      int guard;
      int g;
      ok = 1'b1;
      for (int p = 0; p < np; p++) begin
         for (int r = 0; r < NR; r++) begin
            if (gaps) begin
               g = int'($urandom_range(0, 2));
               repeat (g) begin bus.w_in_valid = 1'b0; @(negedge clk); end
            end
            bus.w_in_valid = 1'b1;
            bus.w_in_data = base + NB'(int'(step) * r);
            guard = 0;
            while (!bus.w_in_ready && guard < 50) begin @(negedge clk); guard++; end
            if (!bus.w_in_ready) begin ok = 1'b0; bus.w_in_valid = 1'b0; return; end
            @(negedge clk);
         end
      end
      bus.w_in_valid = 1'b0;
   endtask

   task automatic drain(input int stall_row);
      int stall_left;
      logic [NB-1:0] sd;
      bit prev_low;
      bit seen;
      dr_n = 0; dr_last_cnt = 0; dr_last_row = -1; dr_clr = 0;
      dr_stall_ok = 1'b1; dr_clr_before_done = 1'b0;
      stall_left = 5; prev_low = 1'b0; seen = 1'b0; sd = '0;
      for (int c = 0; c < 600 && !seen; c++) begin
         @(negedge clk);
         if (!bus.w_glb_ready) dr_clr++;
         if (bus.w_done) begin seen = 1'b1; dr_clr_before_done = prev_low; end
         prev_low = !bus.w_glb_ready;
         bus.w_out_ready = 1'b0;
         if (bus.w_out_valid) begin
            if (dr_n == stall_row && stall_left > 0) begin
               if (stall_left == 5) sd = bus.w_out_data;
               else if (bus.w_out_data !== sd) dr_stall_ok = 1'b0;
               stall_left--;
            end else begin
               bus.w_out_ready = 1'b1;
               if (dr_n < NR) dr_vals[dr_n] = bus.w_out_data;
               if (bus.w_out_last) begin dr_last_cnt++; dr_last_row = dr_n; end
               dr_n++;
            end
         end
      end
      bus.w_out_ready = 1'b0;
      dr_ok = seen;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.w_in_ready, bus.w_out_valid, bus.w_out_last, bus.w_busy, bus.w_done} !== 5'b0)
         $display("FAIL reset_status: got %b expected 00000",
                  {bus.w_in_ready, bus.w_out_valid, bus.w_out_last, bus.w_busy, bus.w_done});
      else passed++;
      checks++;
      if ({bus.w_glb_ready, bus.w_glb_rw, bus.w_glb_add, bus.w_glb_address, bus.w_glb_data_in} !== '0)
         $display("FAIL reset_glb: ready=%b rw=%b add=%b addr=%0d din=%0d expected all 0",
                  bus.w_glb_ready, bus.w_glb_rw, bus.w_glb_add, bus.w_glb_address, bus.w_glb_data_in);
      else passed++;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.w_glb_ready !== 1'b1 || bus.w_busy !== 1'b0)
         $display("FAIL idle_after_reset: glb_ready=%b busy=%b expected 1/0", bus.w_glb_ready, bus.w_busy);
      else passed++;
   endtask

   task automatic test_single_pass();
      bit ok;
      int errs;
      int d0;
      d0 = done_cnt;
      start_job(1);
      feed(1, 8'd1, 8'd1, 1'b0, ok);
      checks++;
      if (!ok || mem[0] !== 8'd1 || mem[63] !== 8'd64)
         $display("FAIL single_write: ok=%0d mem0=%0d mem63=%0d expected 1/1/64", ok, mem[0], mem[63]);
      else passed++;
      drain(-1);
      errs = 0;
      for (int r = 0; r < NR; r++) if (dr_vals[r] !== NB'(r + 1)) errs++;
      checks++;
      if (!dr_ok || dr_n != NR || errs != 0)
         $display("FAIL single_drain: done_seen=%0d rows=%0d bad=%0d expected 1/64/0", dr_ok, dr_n, errs);
      else passed++;
      checks++;
      if (dr_last_cnt != 1 || dr_last_row != 63)
         $display("FAIL single_last: count=%0d row=%0d expected 1/63", dr_last_cnt, dr_last_row);
      else passed++;
      checks++;
      if (dr_clr != EXP_CLR || int'(dr_clr_before_done) != EXP_CLR)
         $display("FAIL single_clear: low_cycles=%0d before_done=%0d expected %0d/%0d",
                  dr_clr, dr_clr_before_done, EXP_CLR, EXP_CLR);
      else passed++;
      repeat (2) @(negedge clk);
      checks++;
      if (done_cnt - d0 != 1 || bus.w_busy !== 1'b0)
         $display("FAIL single_done: pulses=%0d busy=%b expected 1/0", done_cnt - d0, bus.w_busy);
      else passed++;
   endtask

   task automatic test_multi_pass();
      bit ok;
      int errs;
      start_job(3);
      feed(3, 8'd100, 8'd0, 1'b0, ok);
      drain(-1);
      errs = 0;
      for (int r = 0; r < NR; r++) if (dr_vals[r] !== 8'd44) errs++;
      checks++;
      if (!ok || !dr_ok || dr_n != NR || errs != 0)
         $display("FAIL multi_wrap: feed=%0d done=%0d rows=%0d bad=%0d row0=%0d expected 44",
                  ok, dr_ok, dr_n, errs, dr_vals[0]);
      else passed++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_backpressure();
      bit ok;
      int errs;
      start_job(2);
      feed(2, 8'd3, 8'd3, 1'b1, ok);
      drain(10);
      errs = 0;
      for (int r = 0; r < NR; r++) if (dr_vals[r] !== NB'(6 * r + 6)) errs++;
      checks++;
      if (!ok || !dr_ok || dr_n != NR || errs != 0)
         $display("FAIL gaps_drain: feed=%0d done=%0d rows=%0d bad=%0d expected rows=64 bad=0",
                  ok, dr_ok, dr_n, errs);
      else passed++;
      checks++;
      if (!dr_stall_ok || dr_vals[10] !== 8'd66)
         $display("FAIL stall_hold: stable=%0d row10=%0d expected 1/66", dr_stall_ok, dr_vals[10]);
      else passed++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_zero_passes();
      bit ok;
      int errs;
      start_job(0);
      bus.w_start = 1'b1;
      bus.w_num_passes = PW'(3);
      @(negedge clk);
      bus.w_start = 1'b0;
      checks++;
      if (bus.w_busy !== 1'b1 || bus.w_in_ready !== 1'b1)
         $display("FAIL start_in_acc: busy=%b in_ready=%b expected 1/1", bus.w_busy, bus.w_in_ready);
      else passed++;
      feed(1, 8'hA0, 8'd1, 1'b0, ok);
      checks++;
      if (!ok || bus.w_in_ready !== 1'b0)
         $display("FAIL zero_in_ready_drop: feed=%0d in_ready=%b expected 1/0", ok, bus.w_in_ready);
      else passed++;
      drain(-1);
      errs = 0;
      for (int r = 0; r < NR; r++) if (dr_vals[r] !== NB'(160 + r)) errs++;
      checks++;
      if (!dr_ok || dr_n != NR || errs != 0)
         $display("FAIL zero_drain: done=%0d rows=%0d bad=%0d expected 1/64/0", dr_ok, dr_n, errs);
      else passed++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_abort();
      bit ok;
      bit hit;
      int cnt;
      int errs;
      int d0;
      start_job(1);
      feed(1, 8'd1, 8'd1, 1'b0, ok);
      d0 = done_cnt;
      cnt = 0; hit = 1'b0;
      bus.w_out_ready = 1'b1;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(negedge clk);
         if (bus.w_out_valid) begin
            if (cnt == 20) hit = 1'b1;
            else cnt++;
         end
      end
      checks++;
      if (!hit || bus.w_out_data !== 8'd21)
         $display("FAIL abort_reach_row20: reached=%0d data=%0d expected 1/21", hit, bus.w_out_data);
      else passed++;
      bus.w_out_ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.w_out_valid !== 1'b0 || bus.w_busy !== 1'b0 || bus.w_glb_ready !== 1'b0)
         $display("FAIL abort_idle: out_valid=%b busy=%b glb_ready=%b expected 0/0/0",
                  bus.w_out_valid, bus.w_busy, bus.w_glb_ready);
      else passed++;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (done_cnt != d0 || mem[5] !== 8'd0)
         $display("FAIL abort_no_done: pulses=%0d mem5=%0d expected 0/0", done_cnt - d0, mem[5]);
      else passed++;
      start_job(1);
      feed(1, 8'd7, 8'd0, 1'b0, ok);
      drain(-1);
      errs = 0;
      for (int r = 0; r < NR; r++) if (dr_vals[r] !== 8'd7) errs++;
      checks++;
      if (!ok || !dr_ok || dr_n != NR || errs != 0)
         $display("FAIL abort_fresh_job: done=%0d rows=%0d bad=%0d expected 1/64/0", dr_ok, dr_n, errs);
      else passed++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_clear();
      bit ok;
      int errs;
      start_job(2);
      feed(2, 8'd5, 8'd0, 1'b0, ok);
      drain(-1);
      errs = 0;
      for (int r = 0; r < NR; r++) if (dr_vals[r] !== 8'd10) errs++;
      checks++;
      if (!ok || !dr_ok || dr_n != NR || errs != 0)
         $display("FAIL clear_job_drain: done=%0d rows=%0d bad=%0d expected 1/64/0", dr_ok, dr_n, errs);
      else passed++;
      checks++;
      if (dr_clr != EXP_CLR || int'(dr_clr_before_done) != EXP_CLR)
         $display("FAIL clear_cycle: low_cycles=%0d before_done=%0d expected %0d/%0d",
                  dr_clr, dr_clr_before_done, EXP_CLR, EXP_CLR);
      else passed++;
      @(negedge clk);
      checks++;
      if (mem[0] !== (EXP_CLR != 0 ? 8'd0 : 8'd10) || mem[63] !== (EXP_CLR != 0 ? 8'd0 : 8'd10))
         $display("FAIL clear_contents: mem0=%0d mem63=%0d expected %0d",
                  mem[0], mem[63], EXP_CLR != 0 ? 0 : 10);
      else passed++;
   endtask

   initial begin
      bus.w_start = 1'b0;
      bus.w_num_passes = '0;
      bus.w_in_valid = 1'b0;
      bus.w_in_data = '0;
      bus.w_out_ready = 1'b0;
      test_reset();
      test_single_pass();
      test_multi_pass();
      test_backpressure();
      test_zero_passes();
      test_reset_abort();
      test_clear();
      checks++;
      if (bus_viol != 0)
         $display("FAIL bus_discipline: cycles with rw=1 while out_valid=%0d expected 0", bus_viol);
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
